alu_ctrl: RTL and testbench
===========================

ALU_CTRL -- requirements
Module: alu_ctrl

Interface
REQ-001 SHALL have parameter N, default 16, ALU datapath width.
REQ-002 SHALL have parameter NREG, default 8, register-file depth; addresses are 3 bits.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port cmd_valid/cmd_ready  input/output  1/1  command handshake.
REQ-006 SHALL have port cmd_op/cmd_dst/cmd_srca/cmd_srcb  input  3 each  opcode, destination, source addresses.
REQ-007 SHALL have port ld_valid/ld_addr/ld_data  input  1/3/N  direct register-file write.
REQ-008 SHALL have port alu_a/alu_b  output  N each  ALU operands.
REQ-009 SHALL have port alu_reg0/alu_reg1/alu_reg2  output  N each  ALU constants: all-zero, all-ones, one.
REQ-010 SHALL have port alu_f0/alu_f1/alu_ena/alu_enb/alu_inva/alu_inc  output  1 each  ALU control word.
REQ-011 SHALL have port alu_func/alu_ovflag  input  N/1  ALU result and overflow.
REQ-012 SHALL have port res_valid/res_ready/res_data/res_ovf  output/input/output/output  1/1/N/1  result handshake.
REQ-013 SHALL have port ovf_sticky/ovf_clr  output/input  1/1  sticky overflow status and clear.

Function
REQ-014 SHALL implement FSM states IDLE, EXEC, RESP; IDLE->EXEC on accepted command, EXEC->RESP unconditionally after one cycle, RESP->IDLE on res_valid&&res_ready.
REQ-015 SHALL assert cmd_ready only in IDLE with ld_valid low; a command is accepted on a clock edge where cmd_valid&&cmd_ready.
REQ-016 SHALL, on acceptance, register alu_a<=rf[srca], alu_b<=rf[srcb], latch dst, and register the control word from the op table.
REQ-017 SHALL use op table {f1,f0,ena,enb,inva,inc}: op0=000110, op1=000111, op2=001110, op3=000100, op4=100110, op5=110110, op6=100111, op7=000000 (op7 = NOP, no register write).
REQ-018 SHALL, at the EXEC->RESP edge, capture res_data<=alu_func, res_ovf<=alu_ovflag, and write rf[dst]<=alu_func unless dst==0 or op==7.
REQ-019 SHALL give latency of exactly 2 edges from command acceptance to res_valid high; res_valid high only in RESP.
REQ-020 SHALL hold res_data/res_ovf stable while res_valid&&!res_ready.
REQ-021 SHALL drive all six ALU controls and alu_a/alu_b to 0 in IDLE and RESP; drive them only in EXEC.
REQ-022 SHALL drive alu_reg0=0, alu_reg1={N{1}}, alu_reg2=1 constantly.
REQ-023 SHALL read rf[0] as 0 always; writes to address 0 (cmd or ld) are discarded.
REQ-024 SHALL perform ld write rf[ld_addr]<=ld_data only in IDLE; ld_valid outside IDLE is ignored; ld has priority over cmd in IDLE.
REQ-025 SHALL, when srca==srcb==dst, read the pre-write value (write lands at EXEC->RESP edge).
REQ-026 SHALL set ovf_sticky at the capture edge when alu_ovflag=1; clear on ovf_clr; simultaneous set and clear -> set wins.
REQ-027 SHALL support back-to-back commands: next acceptance no earlier than the edge after RESP exits; cmd_ready in the cycle following the RESP handshake.

Reset
REQ-028 SHALL, on rstn low, asynchronously force state IDLE, all rf entries, res_data, res_ovf, res_valid, ovf_sticky, alu_a, alu_b and all ALU controls to 0.
REQ-029 SHALL abort an in-flight command on reset mid-EXEC or mid-RESP with no register write and no result delivered.
REQ-030 SHALL assert cmd_ready in the first cycle after rstn deasserts (with ld_valid low).

Verification
REQ-031 SHALL pass: ld r1=0x0005, r2=0x0003; cmd op0 dst=3 srca=1 srcb=2 with stub ALU returning 0x0008 -> alu_a=0x0005, alu_b=0x0003, controls 000110 in EXEC, res_valid 2 edges later, res_data=0x0008, rf[3]=0x0008.
REQ-032 SHALL pass: res_ready held low 5 cycles -> res_valid and res_data constant, cmd_ready low throughout.
REQ-033 SHALL pass: stub alu_ovflag=1 on a command -> res_ovf=1, ovf_sticky=1; ovf_clr pulse -> 0; ovf_clr coincident with new overflow capture -> stays 1.
REQ-034 SHALL pass: cmd dst=0 or op7 -> result delivered, rf unchanged; ld to address 0 -> rf[0] reads 0.
REQ-035 SHALL pass: rstn low during EXEC -> all outputs 0 immediately, rf[dst] unchanged at 0, no res_valid after release.
REQ-036 SHALL pass: ld_valid and cmd_valid both high in IDLE -> ld applied, cmd_ready low, command accepted next cycle.

Source files
------------

// File: rtl/alu_ctrl.sv
// Sequencer for an external ALU: 3-state command FSM, small register file,
// registered ALU operand/control outputs and a result handshake with sticky overflow.
//
//   state | meaning
//   IDLE  | waiting for a command; direct register loads are accepted here
//   EXEC  | operands and control word presented to the ALU for one cycle
//   RESP  | captured result held on res_data until res_ready
module alu_ctrl #(
  parameter int N    = 16,
  parameter int NREG = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [2:0]   cmd_op,
  input  logic [2:0]   cmd_dst,
  input  logic [2:0]   cmd_srca,
  input  logic [2:0]   cmd_srcb,
  input  logic         ld_valid,
  input  logic [2:0]   ld_addr,
  input  logic [N-1:0] ld_data,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [N-1:0] alu_reg0,
  output logic [N-1:0] alu_reg1,
  output logic [N-1:0] alu_reg2,
  output logic         alu_f0,
  output logic         alu_f1,
  output logic         alu_ena,
  output logic         alu_enb,
  output logic         alu_inva,
  output logic         alu_inc,
  input  logic [N-1:0] alu_func,
  input  logic         alu_ovflag,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [N-1:0] res_data,
  output logic         res_ovf,
  output logic         ovf_sticky,
  input  logic         ovf_clr
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   rf_q [NREG];
  logic [N-1:0]   a_q, b_q, res_data_q;
  logic [5:0]     ctrl_q;
  logic [2:0]     dst_q, op_q;
  logic           res_ovf_q, sticky_q;
  logic           accept, capture;
  logic           rf_we;
  logic [2:0]     rf_waddr;
  logic [N-1:0]   rf_wdata;

  // Control word bit order: {f1, f0, ena, enb, inva, inc}
  function automatic logic [5:0] op_ctrl(input logic [2:0] op);
    case (op)
      3'd0:    op_ctrl = 6'b000110;
      3'd1:    op_ctrl = 6'b000111;
      3'd2:    op_ctrl = 6'b001110;
      3'd3:    op_ctrl = 6'b000100;
      3'd4:    op_ctrl = 6'b100110;
      3'd5:    op_ctrl = 6'b110110;
      3'd6:    op_ctrl = 6'b100111;
      default: op_ctrl = 6'b000000;
    endcase
  endfunction

  assign cmd_ready = (state_q == IDLE) && !ld_valid;
  assign accept    = cmd_valid && cmd_ready;
  assign capture   = (state_q == EXEC);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Single write port: loads only in IDLE, ALU results at the EXEC->RESP edge.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = ld_addr;
    rf_wdata = ld_data;
    if (state_q == IDLE && ld_valid) begin
      rf_we = 1'b1;
    end else if (capture && op_q != 3'd7) begin
      rf_we    = 1'b1;
      rf_waddr = dst_q;
      rf_wdata = alu_func;
    end
    if (rf_waddr == 3'd0) rf_we = 1'b0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else if (rf_we) begin
      rf_q[rf_waddr] <= rf_wdata;
    end
  end

  // Operands/controls live only for the EXEC cycle, so they are cleared on capture.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      a_q        <= '0;
      b_q        <= '0;
      ctrl_q     <= '0;
      dst_q      <= '0;
      op_q       <= '0;
      res_data_q <= '0;
      res_ovf_q  <= 1'b0;
    end else if (accept) begin
      a_q    <= rf_q[cmd_srca];
      b_q    <= rf_q[cmd_srcb];
      ctrl_q <= op_ctrl(cmd_op);
      dst_q  <= cmd_dst;
      op_q   <= cmd_op;
    end else if (capture) begin
      a_q        <= '0;
      b_q        <= '0;
      ctrl_q     <= '0;
      res_data_q <= alu_func;
      res_ovf_q  <= alu_ovflag;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                     sticky_q <= 1'b0;
    else if (capture && alu_ovflag) sticky_q <= 1'b1;
    else if (ovf_clr)              sticky_q <= 1'b0;
  end

  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_f1     = ctrl_q[5];
  assign alu_f0     = ctrl_q[4];
  assign alu_ena    = ctrl_q[3];
  assign alu_enb    = ctrl_q[2];
  assign alu_inva   = ctrl_q[1];
  assign alu_inc    = ctrl_q[0];
  assign alu_reg0   = '0;
  assign alu_reg1   = '1;
  assign alu_reg2   = N'(1);
  assign res_valid  = (state_q == RESP);
  assign res_data   = res_data_q;
  assign res_ovf    = res_ovf_q;
  assign ovf_sticky = sticky_q;

endmodule

// File: tb/tb_alu_ctrl.sv
// Self-checking bench for alu_ctrl: stub ALU driven by the bench, register file and
// sticky flag tracked by a simple array model, directed scenarios plus random commands.
module tb_alu_ctrl;
  logic        clk = 1'b0;
  logic        rstn;
  logic        cmd_valid, cmd_ready;
  logic [2:0]  cmd_op, cmd_dst, cmd_srca, cmd_srcb;
  logic        ld_valid;
  logic [2:0]  ld_addr;
  logic [15:0] ld_data;
  logic [15:0] alu_a, alu_b, alu_reg0, alu_reg1, alu_reg2;
  logic        alu_f0, alu_f1, alu_ena, alu_enb, alu_inva, alu_inc;
  logic [15:0] alu_func;
  logic        alu_ovflag;
  logic        res_valid, res_ready, res_ovf, ovf_sticky, ovf_clr;
  logic [15:0] res_data;
  logic [5:0]  ctrl;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] m_rf [8];
  logic        m_sticky;
  logic [5:0]  tbl [8] = '{6'b000110, 6'b000111, 6'b001110, 6'b000100,
                           6'b100110, 6'b110110, 6'b100111, 6'b000000};

  alu_ctrl dut (
    .clk(clk), .rstn(rstn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_dst(cmd_dst), .cmd_srca(cmd_srca), .cmd_srcb(cmd_srcb),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
    .alu_a(alu_a), .alu_b(alu_b),
    .alu_reg0(alu_reg0), .alu_reg1(alu_reg1), .alu_reg2(alu_reg2),
    .alu_f0(alu_f0), .alu_f1(alu_f1), .alu_ena(alu_ena), .alu_enb(alu_enb),
    .alu_inva(alu_inva), .alu_inc(alu_inc),
    .alu_func(alu_func), .alu_ovflag(alu_ovflag),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_ovf(res_ovf),
    .ovf_sticky(ovf_sticky), .ovf_clr(ovf_clr)
  );

  assign ctrl = {alu_f1, alu_f0, alu_ena, alu_enb, alu_inva, alu_inc};

  always #5 clk = ~clk;

  // Every task starts and ends shortly after a falling edge.
  task automatic do_cmd(input logic [2:0] op, input logic [2:0] dst, input logic [2:0] sa,
                        input logic [2:0] sb, input logic [15:0] func, input logic ovf,
                        input int hold, input logic clr, input logic with_ld,
                        input logic [2:0] la, input logic [15:0] ldd, input logic junk_ld);
    logic [15:0] exp_res;
    cmd_valid = 1'b1; cmd_op = op; cmd_dst = dst; cmd_srca = sa; cmd_srcb = sb;
    if (with_ld) begin
      ld_valid = 1'b1; ld_addr = la; ld_data = ldd;
      #1;
      n_checks++;
      if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL ld_prio_ready: got %b want 0", cmd_ready); end
      @(posedge clk); @(negedge clk);
      ld_valid = 1'b0;
      if (la != 3'd0) m_rf[la] = ldd;
    end
    #1;
    n_checks++;
    if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL idle_ready: got %b want 1", cmd_ready); end
    @(posedge clk); @(negedge clk);
    cmd_valid = 1'b0;
    n_checks++;
    if (alu_a !== m_rf[sa]) begin n_fail++; $display("FAIL exec_alu_a: got %h want %h", alu_a, m_rf[sa]); end
    n_checks++;
    if (alu_b !== m_rf[sb]) begin n_fail++; $display("FAIL exec_alu_b: got %h want %h", alu_b, m_rf[sb]); end
    n_checks++;
    if (ctrl !== tbl[op]) begin n_fail++; $display("FAIL exec_ctrl op%0d: got %b want %b", op, ctrl, tbl[op]); end
    n_checks++;
    if ({res_valid, cmd_ready} !== 2'b00) begin n_fail++; $display("FAIL exec_hs: got %b want 00", {res_valid, cmd_ready}); end
    alu_func = func; alu_ovflag = ovf; ovf_clr = clr;
    if (junk_ld) begin ld_valid = 1'b1; ld_addr = 3'($urandom_range(1, 7)); ld_data = 16'($urandom); end
    @(posedge clk); @(negedge clk);
    exp_res = func;
    if (dst != 3'd0 && op != 3'd7) m_rf[dst] = func;
    if (ovf) m_sticky = 1'b1;
    else if (clr) m_sticky = 1'b0;
    ovf_clr = 1'b0;
    alu_func = 16'($urandom); alu_ovflag = 1'($urandom);
    n_checks++;
    if (res_valid !== 1'b1) begin n_fail++; $display("FAIL resp_valid: got %b want 1", res_valid); end
    n_checks++;
    if (res_data !== exp_res) begin n_fail++; $display("FAIL resp_data: got %h want %h", res_data, exp_res); end
    n_checks++;
    if (res_ovf !== ovf) begin n_fail++; $display("FAIL resp_ovf: got %b want %b", res_ovf, ovf); end
    n_checks++;
    if (ovf_sticky !== m_sticky) begin n_fail++; $display("FAIL resp_sticky: got %b want %b", ovf_sticky, m_sticky); end
    n_checks++;
    if ({alu_a, alu_b, ctrl} !== 38'd0) begin n_fail++; $display("FAIL resp_alu_idle: got %h/%h/%b want 0", alu_a, alu_b, ctrl); end
    for (int i = 0; i < hold; i++) begin
      res_ready = 1'b0;
      if (junk_ld) begin ld_valid = 1'b1; ld_addr = 3'($urandom_range(1, 7)); ld_data = 16'($urandom); end
      @(posedge clk); @(negedge clk);
      alu_func = 16'($urandom);
      n_checks++;
      if ({res_valid, cmd_ready} !== 2'b10) begin n_fail++; $display("FAIL stall_hs: got %b want 10", {res_valid, cmd_ready}); end
      n_checks++;
      if ({res_data, res_ovf} !== {exp_res, ovf}) begin n_fail++; $display("FAIL stall_data: got %h/%b want %h/%b", res_data, res_ovf, exp_res, ovf); end
    end
    res_ready = 1'b1; ld_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    res_ready = 1'b0;
    #1;
    n_checks++;
    if ({res_valid, cmd_ready} !== 2'b01) begin n_fail++; $display("FAIL post_hs: got %b want 01", {res_valid, cmd_ready}); end
  endtask

  task automatic do_ld(input logic [2:0] a, input logic [15:0] d);
    ld_valid = 1'b1; ld_addr = a; ld_data = d;
    @(posedge clk); @(negedge clk);
    ld_valid = 1'b0;
    if (a != 3'd0) m_rf[a] = d;
  endtask

  task automatic read_regs();
    for (int i = 0; i < 8; i += 2)
      do_cmd(3'd7, 3'd0, 3'(i), 3'(i + 1), 16'($urandom), 1'b0, 0, 1'b0, 1'b0, 3'd0, 16'd0, 1'b0);
  endtask

  task automatic test_reset();
    rstn = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_dst = '0; cmd_srca = '0; cmd_srcb = '0;
    ld_valid = 1'b0; ld_addr = '0; ld_data = '0; alu_func = '0; alu_ovflag = 1'b0;
    res_ready = 1'b0; ovf_clr = 1'b0;
    for (int i = 0; i < 8; i++) m_rf[i] = '0;
    m_sticky = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({res_valid, res_data, res_ovf, ovf_sticky, alu_a, alu_b, ctrl} !== 57'd0) begin
      n_fail++; $display("FAIL reset_outputs: got %b/%h/%b/%b/%h/%h/%b want 0", res_valid, res_data, res_ovf, ovf_sticky, alu_a, alu_b, ctrl);
    end
    n_checks++;
    if ({alu_reg0, alu_reg1, alu_reg2} !== {16'h0000, 16'hFFFF, 16'h0001}) begin
      n_fail++; $display("FAIL reset_consts: got %h %h %h want 0000 ffff 0001", alu_reg0, alu_reg1, alu_reg2);
    end
    rstn = 1'b1;
    #1;
    n_checks++;
    if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", cmd_ready); end
    read_regs();
  endtask

  task automatic test_basic();
    do_ld(3'd1, 16'h0005);
    do_ld(3'd2, 16'h0003);
    do_cmd(3'd0, 3'd3, 3'd1, 3'd2, 16'h0008, 1'b0, 0, 1'b0, 1'b0, 3'd0, 16'd0, 1'b0);
    do_cmd(3'd7, 3'd0, 3'd3, 3'd1, 16'h1111, 1'b0, 0, 1'b0, 1'b0, 3'd0, 16'd0, 1'b0);
    n_checks++;
    if (m_rf[3] !== 16'h0008) begin n_fail++; $display("FAIL basic_model_r3: got %h want 0008", m_rf[3]); end
  endtask

  task automatic test_stall();
    do_cmd(3'd2, 3'd4, 3'd1, 3'd3, 16'hA5A5, 1'b0, 5, 1'b0, 1'b0, 3'd0, 16'd0, 1'b1);
    read_regs();
  endtask

  task automatic test_ovf();
    do_cmd(3'd1, 3'd5, 3'd1, 3'd2, 16'h7FFF, 1'b1, 0, 1'b0, 1'b0, 3'd0, 16'd0, 1'b0);
    ovf_clr = 1'b1;
    @(posedge clk); @(negedge clk);
    ovf_clr = 1'b0; m_sticky = 1'b0;
    n_checks++;
    if (ovf_sticky !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %b want 0", ovf_sticky); end
    do_cmd(3'd4, 3'd6, 3'd5, 3'd5, 16'h8000, 1'b1, 1, 1'b0, 1'b0, 3'd0, 16'd0, 1'b0);
    do_cmd(3'd5, 3'd6, 3'd6, 3'd1, 16'h8001, 1'b1, 0, 1'b1, 1'b0, 3'd0, 16'd0, 1'b0);
    do_cmd(3'd6, 3'd6, 3'd6, 3'd2, 16'h0042, 1'b0, 0, 1'b1, 1'b0, 3'd0, 16'd0, 1'b0);
  endtask

  task automatic test_discard();
    do_cmd(3'd0, 3'd0, 3'd1, 3'd2, 16'h1234, 1'b0, 0, 1'b0, 1'b0, 3'd0, 16'd0, 1'b0);
    do_cmd(3'd7, 3'd4, 3'd1, 3'd2, 16'h5555, 1'b0, 0, 1'b0, 1'b0, 3'd0, 16'd0, 1'b0);
    do_ld(3'd0, 16'hFFFF);
    do_cmd(3'd7, 3'd0, 3'd0, 3'd4, 16'h0000, 1'b0, 0, 1'b0, 1'b0, 3'd0, 16'd0, 1'b0);
  endtask

  task automatic test_same_reg();
    do_ld(3'd5, 16'h0100);
    do_cmd(3'd1, 3'd5, 3'd5, 3'd5, 16'h0201, 1'b0, 0, 1'b0, 1'b0, 3'd0, 16'd0, 1'b0);
    do_cmd(3'd7, 3'd0, 3'd5, 3'd5, 16'h0000, 1'b0, 0, 1'b0, 1'b0, 3'd0, 16'd0, 1'b0);
  endtask

  task automatic test_ld_priority();
    do_cmd(3'd3, 3'd7, 3'd6, 3'd2, 16'h0F0F, 1'b0, 0, 1'b0, 1'b1, 3'd6, 16'hC0DE, 1'b0);
  endtask

  task automatic test_reset_abort(input logic in_resp);
    cmd_valid = 1'b1; cmd_op = 3'd0; cmd_dst = 3'd3; cmd_srca = 3'd1; cmd_srcb = 3'd2;
    @(posedge clk); @(negedge clk);
    cmd_valid = 1'b0; alu_func = 16'hBEEF; alu_ovflag = 1'b1;
    if (in_resp) begin @(posedge clk); @(negedge clk); end
    #2 rstn = 1'b0;
    #1;
    n_checks++;
    if ({res_valid, res_data, res_ovf, ovf_sticky, alu_a, alu_b, ctrl} !== 57'd0) begin
      n_fail++; $display("FAIL abort_outputs resp=%b: got %b/%h/%b/%b/%h/%h/%b want 0", in_resp, res_valid, res_data, res_ovf, ovf_sticky, alu_a, alu_b, ctrl);
    end
    for (int i = 0; i < 8; i++) m_rf[i] = '0;
    m_sticky = 1'b0;
    alu_func = '0; alu_ovflag = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    n_checks++;
    if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL abort_ready: got %b want 1", cmd_ready); end
    res_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); @(negedge clk);
      n_checks++;
      if (res_valid !== 1'b0) begin n_fail++; $display("FAIL abort_no_result: got %b want 0", res_valid); end
    end
    res_ready = 1'b0;
    read_regs();
  endtask

  task automatic test_random();
    for (int k = 0; k < 40; k++) begin
      do_cmd(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
             3'($urandom_range(0, 7)), 16'($urandom), 1'($urandom), $urandom_range(0, 2),
             1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
             3'($urandom_range(0, 7)), 16'($urandom), 1'($urandom));
    end
    read_regs();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_ovf();
    test_discard();
    test_same_reg();
    test_ld_priority();
    test_reset_abort(1'b0);
    do_ld(3'd1, 16'h0011);
    do_ld(3'd2, 16'h0022);
    test_reset_abort(1'b1);
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout want finish");
    $fatal(1);
  end
endmodule
